// File: rtl/lsu_mem_ctrl_if.sv
// Pipeline-side request/write-back and data-memory bus signals of the load/store unit.
// The master modport is the LSU itself; the slave modport is the pipeline plus memory.
interface lsu_mem_ctrl_if;
    logic        req_valid;
    logic        req_store;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    logic        stall;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        fault;
    logic [1:0]  fault_code;

    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        input  req_valid, req_store, req_func3, req_addr, req_wdata, req_rd,
        input  mem_ready, mem_rvalid, mem_rdata,
        output stall, wb_en, wb_rd, wb_data, fault, fault_code,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_store, req_func3, req_addr, req_wdata, req_rd,
        output mem_ready, mem_rvalid, mem_rdata,
        input  stall, wb_en, wb_rd, wb_data, fault, fault_code,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: lane-aligns stores, extends loads, and stalls the pipeline while a
// data-memory access is in flight. Accesses that overrun TIMEOUT_CYCLES end in a bus fault.
module lsu_mem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic            clk,
    input logic            reset,
    lsu_mem_ctrl_if.master lsu_if
);
    localparam int unsigned CntW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast =
        (TIMEOUT_CYCLES == 0) ? '0 : CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    typedef enum logic [1:0] {StIdle, StReq, StWaitR, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     addr_q, addr_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [4:0]      rd_q, rd_d;
    logic [2:0]      func3_q, func3_d;
    logic            store_q, store_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            to_q, to_d;

    logic [1:0]  req_off;
    logic        illegal;
    logic        misaligned;
    logic [3:0]  store_be;
    logic [31:0] store_wdata;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic        timeout_hit;
    logic        load_done;

    // Request decode: legality, alignment and store lane placement.
    always_comb begin
        req_off    = lsu_if.req_addr[1:0];
        illegal    = lsu_if.req_func3 inside {3'b011, 3'b110, 3'b111};
        misaligned = ((lsu_if.req_func3[1:0] == 2'b01) && req_off[0]) ||
                     ((lsu_if.req_func3[1:0] == 2'b10) && (req_off != 2'b00));
        unique case (lsu_if.req_func3[1:0])
            2'b00: begin
                store_be    = 4'b0001 << req_off;
                store_wdata = {4{lsu_if.req_wdata[7:0]}};
            end
            2'b01: begin
                store_be    = 4'b0011 << req_off;
                store_wdata = {2{lsu_if.req_wdata[15:0]}};
            end
            default: begin
                store_be    = 4'b1111;
                store_wdata = lsu_if.req_wdata;
            end
        endcase
    end

    always_comb begin
        byte_sel = lsu_if.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_sel = lsu_if.mem_rdata[{addr_q[1], 4'b0000} +: 16];
        case (func3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'h0, byte_sel};
            3'b101:  load_ext = {16'h0, half_sel};
            default: load_ext = lsu_if.mem_rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        func3_d  = func3_q;
        store_d  = store_q;
        rdata_d  = rdata_q;
        to_d     = to_q;
        load_done = 1'b0;

        lsu_if.stall      = 1'b0;
        lsu_if.wb_en      = 1'b0;
        lsu_if.wb_rd      = 5'd0;
        lsu_if.wb_data    = 32'h0;
        lsu_if.fault      = 1'b0;
        lsu_if.fault_code = 2'b00;
        lsu_if.mem_req    = 1'b0;
        lsu_if.mem_we     = 1'b0;
        lsu_if.mem_be     = 4'b0000;
        lsu_if.mem_addr   = 32'h0;
        lsu_if.mem_wdata  = 32'h0;

        timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CntLast);

        unique case (state_q)
            StIdle: begin
                // Gate with reset so the combinational IDLE outputs are also 0 in reset.
                if (lsu_if.req_valid && reset) begin
                    if (illegal) begin
                        lsu_if.fault      = 1'b1;
                        lsu_if.fault_code = 2'b11;
                    end else if (misaligned) begin
                        lsu_if.fault      = 1'b1;
                        lsu_if.fault_code = 2'b01;
                    end else begin
                        lsu_if.stall = 1'b1;
                        state_d      = StReq;
                        addr_d       = lsu_if.req_addr;
                        be_d         = lsu_if.req_store ? store_be : 4'b1111;
                        wdata_d      = lsu_if.req_store ? store_wdata : 32'h0;
                        rd_d         = lsu_if.req_rd;
                        func3_d      = lsu_if.req_func3;
                        store_d      = lsu_if.req_store;
                        to_d         = 1'b0;
                    end
                end
            end
            StReq: begin
                lsu_if.stall     = 1'b1;
                lsu_if.mem_req   = 1'b1;
                lsu_if.mem_we    = store_q;
                lsu_if.mem_be    = be_q;
                lsu_if.mem_addr  = {addr_q[31:2], 2'b00};
                lsu_if.mem_wdata = wdata_q;
                cnt_d            = cnt_q + CntOne;
                // Completion in the last allowed cycle wins over the timeout.
                if (lsu_if.mem_ready && (store_q || lsu_if.mem_rvalid)) begin
                    state_d   = StDone;
                    load_done = !store_q;
                end else if (timeout_hit) begin
                    state_d = StDone;
                    to_d    = 1'b1;
                end else if (lsu_if.mem_ready) begin
                    state_d = StWaitR;
                end
            end
            StWaitR: begin
                lsu_if.stall = 1'b1;
                cnt_d        = cnt_q + CntOne;
                if (lsu_if.mem_rvalid) begin
                    state_d   = StDone;
                    load_done = 1'b1;
                end else if (timeout_hit) begin
                    state_d = StDone;
                    to_d    = 1'b1;
                end
            end
            StDone: begin
                if (!store_q && !to_q) begin
                    lsu_if.wb_en   = 1'b1;
                    lsu_if.wb_rd   = rd_q;
                    lsu_if.wb_data = rdata_q;
                end
                lsu_if.fault      = to_q;
                lsu_if.fault_code = to_q ? 2'b10 : 2'b00;
                to_d              = 1'b0;
                state_d           = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (load_done) rdata_d = load_ext;
        if (!(state_d inside {StReq, StWaitR})) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= 32'h0;
            be_q    <= 4'b0000;
            wdata_q <= 32'h0;
            rd_q    <= 5'd0;
            func3_q <= 3'b000;
            store_q <= 1'b0;
            rdata_q <= 32'h0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            func3_q <= func3_d;
            store_q <= store_d;
            rdata_q <= rdata_d;
            to_q    <= to_d;
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed cases plus random transactions, each checked cycle by
// cycle against a transaction-level model of lane placement, extension, faults and latency.
module tb_lsu_mem_ctrl;
    localparam int Tmo = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    lsu_mem_ctrl_if bus ();

    lsu_mem_ctrl #(
        .TIMEOUT_CYCLES(Tmo)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .lsu_if(bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got sim time %0t required finish earlier", $time);
        $fatal(1, "bench watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int exp_code(input logic [2:0] f3, input logic [31:0] addr);
        int off;
        off = int'(addr[1:0]);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 3;
        if (size_of(f3) == 2 && (off % 2) == 1) return 1;
        if (size_of(f3) == 4 && off != 0) return 1;
        return 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] addr);
        return 4'(((1 << size_of(f3)) - 1) << int'(addr[1:0]));
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (size_of(f3))
            1:       return (wd % 256) * 32'h0101_0101;
            2:       return (wd % 65536) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        longint val;
        int     size;
        int     lane;
        size = size_of(f3);
        if (size == 4) return rdata;
        lane = (size == 2) ? (int'(addr[1:0]) / 2) * 2 : int'(addr[1:0]);
        val  = (longint'(rdata) >> (8 * lane)) % (longint'(1) << (8 * size));
        if (f3 < 3'd4 && val >= (longint'(1) << (8 * size - 1)))
            val = val - (longint'(1) << (8 * size));
        return 32'(val);
    endfunction

    // One request: bus accepts rdy_dly cycles after the first REQ cycle; load data arrives
    // rv_dly cycles after acceptance (0 = same cycle).
    task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [4:0] rd, input int rdy_dly,
                           input int rv_dly, input logic [31:0] rdata);
        int code;
        int a;
        int c;
        int done_k;
        bit tmo;
        code = exp_code(f3, addr);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_func3  = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        bus.req_rd     = rd;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'($urandom_range(0, 1));
        bus.mem_rdata  = $urandom;
        #1;
        if (code != 0) begin
            check_eq("flt_pulse", bus.fault, 1);
            check_eq("flt_code", bus.fault_code, code);
            check_eq("flt_stall", bus.stall, 0);
            check_eq("flt_memreq", bus.mem_req, 0);
            @(negedge clk);
            bus.req_valid  = 1'b0;
            bus.mem_rvalid = 1'b0;
            #1;
            check_eq("flt_noreq", bus.mem_req, 0);
            check_eq("flt_clear", bus.fault, 0);
            return;
        end
        check_eq("acc_stall", bus.stall, 1);
        check_eq("acc_fault", bus.fault, 0);
        a      = rdy_dly + 1;
        c      = st ? a : a + rv_dly;
        tmo    = c > Tmo;
        done_k = tmo ? Tmo + 1 : c + 1;
        for (int k = 1; k <= done_k; k++) begin
            @(negedge clk);
            bus.mem_ready  = (k == a);
            bus.mem_rvalid = !st && (k == a + rv_dly);
            bus.mem_rdata  = bus.mem_rvalid ? rdata : $urandom;
            if (k == done_k) bus.mem_rvalid = 1'($urandom_range(0, 1));
            #1;
            if (k < done_k) begin
                check_eq("busy_stall", bus.stall, 1);
                check_eq("busy_memreq", bus.mem_req, (k <= a) ? 1 : 0);
                check_eq("busy_wben", bus.wb_en, 0);
                check_eq("busy_fault", bus.fault, 0);
                if (k <= a) begin
                    check_eq("mem_we", bus.mem_we, st);
                    check_eq("mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
                    check_eq("mem_be", bus.mem_be, st ? exp_be(f3, addr) : 4'hf);
                    if (st) check_eq("mem_wdata", bus.mem_wdata, exp_wdata(f3, wd));
                end
            end else begin
                check_eq("done_stall", bus.stall, 0);
                check_eq("done_memreq", bus.mem_req, 0);
                check_eq("done_wben", bus.wb_en, (!st && !tmo) ? 1 : 0);
                check_eq("done_fault", bus.fault, tmo ? 1 : 0);
                if (tmo) check_eq("tmo_code", bus.fault_code, 2);
                if (!st && !tmo) begin
                    check_eq("wb_rd", bus.wb_rd, rd);
                    check_eq("wb_data", bus.wb_data, exp_load(f3, addr, rdata));
                end
            end
        end
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        #1;
        check_eq("post_wben", bus.wb_en, 0);
        check_eq("post_fault", bus.fault, 0);
        check_eq("post_stall", bus.stall, 0);
        check_eq("post_memreq", bus.mem_req, 0);
    endtask

    logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0] ill_f3 [3] = '{3'd3, 3'd6, 3'd7};

    initial begin
        logic       st;
        logic [2:0] f3;
        int         rdy;
        int         rv;

        reset          = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_store  = 1'b0;
        bus.req_func3  = 3'b010;
        bus.req_addr   = 32'h0000_0100;
        bus.req_wdata  = 32'h0;
        bus.req_rd     = 5'd1;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        #2;
        check_eq("rst_stall", bus.stall, 0);
        check_eq("rst_memreq", bus.mem_req, 0);
        check_eq("rst_wben", bus.wb_en, 0);
        check_eq("rst_fault", bus.fault, 0);
        check_eq("rst_be", bus.mem_be, 0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        run_txn(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 5'd0, 0, 0, 32'h0);
        run_txn(1'b0, 3'b000, 32'h0000_2001, 32'h0, 5'd7, 0, 1, 32'h0000_8000);
        run_txn(1'b0, 3'b100, 32'h0000_2001, 32'h0, 5'd8, 0, 1, 32'h0000_8000);
        run_txn(1'b0, 3'b001, 32'h0000_2002, 32'h0, 5'd9, 0, 1, 32'h8001_0000);
        run_txn(1'b0, 3'b101, 32'h0000_2002, 32'h0, 5'd10, 1, 0, 32'h8001_0000);
        run_txn(1'b0, 3'b010, 32'h0000_2002, 32'h0, 5'd11, 0, 0, 32'h0);
        run_txn(1'b0, 3'b011, 32'h0000_2000, 32'h0, 5'd12, 0, 0, 32'h0);
        run_txn(1'b1, 3'b001, 32'h0000_1001, 32'h1234_5678, 5'd0, 0, 0, 32'h0);
        run_txn(1'b1, 3'b001, 32'h0000_1002, 32'h1234_BEEF, 5'd0, 1, 0, 32'h0);
        run_txn(1'b1, 3'b010, 32'h0000_4000, 32'hCAFE_F00D, 5'd0, 100, 0, 32'h0);
        run_txn(1'b0, 3'b010, 32'h0000_4004, 32'h0, 5'd13, 0, 100, 32'h0);
        run_txn(1'b0, 3'b010, 32'h0000_0010, 32'h0, 5'd0, 0, 0, 32'hDEAD_BEEF);

        // Reset while a load waits for read data.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_store = 1'b0;
        bus.req_func3 = 3'b010;
        bus.req_addr  = 32'h0000_3000;
        bus.req_rd    = 5'd3;
        @(negedge clk);
        bus.mem_ready = 1'b1;
        #1;
        check_eq("ab_memreq", bus.mem_req, 1);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        check_eq("ab_waitr_stall", bus.stall, 1);
        reset = 1'b0;
        #1;
        check_eq("ab_rst_memreq", bus.mem_req, 0);
        check_eq("ab_rst_stall", bus.stall, 0);
        check_eq("ab_rst_wben", bus.wb_en, 0);
        check_eq("ab_rst_fault", bus.fault, 0);
        @(negedge clk);
        bus.req_valid  = 1'b0;
        reset          = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h5555_AAAA;
        #1;
        check_eq("late_wben", bus.wb_en, 0);
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        #1;
        check_eq("late_wben2", bus.wb_en, 0);
        check_eq("late_stall", bus.stall, 0);
        run_txn(1'b0, 3'b010, 32'h0000_3000, 32'h0, 5'd3, 0, 1, 32'h0BAD_F00D);

        for (int i = 0; i < 80; i++) begin
            st = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) f3 = ill_f3[$urandom_range(0, 2)];
            else if (st) f3 = ld_f3[$urandom_range(0, 2)];
            else f3 = ld_f3[$urandom_range(0, 4)];
            if ($urandom_range(0, 7) == 0) rdy = $urandom_range(4, 6);
            else rdy = $urandom_range(0, 1);
            rv = $urandom_range(0, 1);
            run_txn(st, f3, $urandom, $urandom, 5'($urandom), rdy, rv, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
